// File: rtl/sync_mem_team1_pkg.sv
// Shared error codes and FSM state encoding for the sync_mem_team1 memory block.
// Optional parity protection is enabled by defining SYNC_MEM_PARITY_EN.
package sync_mem_team1_pkg;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_PROT   = 2'b01;
   localparam logic [1:0] ERR_CMD    = 2'b10;
   localparam logic [1:0] ERR_PARITY = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/sync_mem_array_team1.sv
// Storage array with one write port and an RD_LAT-deep registered read pipeline.
// With SYNC_MEM_PARITY_EN defined each word carries an even-parity bit.
module sync_mem_array_team1
   import sync_mem_team1_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
`ifdef SYNC_MEM_PARITY_EN
   output logic              rd_perr,
`endif
   output logic [DATA_W-1:0] rd_data
);

`ifdef SYNC_MEM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   logic [MEM_W-1:0] mem  [2**ADDR_W];
   logic [MEM_W-1:0] pipe [RD_LAT];
   logic [MEM_W-1:0] word;

`ifdef SYNC_MEM_PARITY_EN
   assign word    = {^wdata, wdata};
   assign rd_perr = ^pipe[RD_LAT-1];
`else
   assign word    = wdata;
`endif

   assign rd_data = pipe[RD_LAT-1][DATA_W-1:0];

   // NOTE: storage and read pipeline carry no reset; the controller never
   // consumes pipeline data before a read has filled it, so a reset net here is pure cost.
   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= word;
      pipe[0] <= mem[addr];
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
   end

endmodule

// File: rtl/sync_mem_team1.sv
// Request/response front end for the data memory: decode, latency counter, response hold.
// Optional parity checking is enabled by defining SYNC_MEM_PARITY_EN.
module sync_mem_team1
   import sync_mem_team1_pkg::*;
#(
   parameter int                DATA_W    = 16,
   parameter int                ADDR_W    = 12,
   parameter int                RD_LAT    = 1,
   parameter logic [ADDR_W-1:0] PROT_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_read,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [1:0]        err_code
);

   state_t            state;
   logic [1:0]        cnt;
   logic              accept;
   logic              cmd_bad;
   logic              prot_hit;
   logic              wr_en;
   logic [DATA_W-1:0] rd_data;
`ifdef SYNC_MEM_PARITY_EN
   logic              rd_perr;
`endif

   assign accept   = (state == IDLE) && req_valid && req_ready;
   assign cmd_bad  = (req_read == req_write);
   assign prot_hit = (req_addr == PROT_ADDR);
   assign wr_en    = accept && !cmd_bad && !prot_hit && req_write;

   sync_mem_array_team1 #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .RD_LAT (RD_LAT)
   ) u_array (
      .clk     (clk),
      .wr_en   (wr_en),
      .addr    (req_addr),
      .wdata   (req_wdata),
`ifdef SYNC_MEM_PARITY_EN
      .rd_perr (rd_perr),
`endif
      .rd_data (rd_data)
   );

   // NOTE: every register here uses <= so all of them see pre-edge values of one another.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  rsp_rdata <= '0;
                  if (cmd_bad) begin
                     rsp_err  <= 1'b1;
                     err_code <= ERR_CMD;
                     state    <= RESP;
                  end else if (prot_hit) begin
                     rsp_err  <= 1'b1;
                     err_code <= ERR_PROT;
                     state    <= RESP;
                  end else if (req_write) begin
                     rsp_err  <= 1'b0;
                     err_code <= ERR_NONE;
                     state    <= RESP;
                  end else begin
                     cnt   <= 2'(RD_LAT - 1);
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (cnt == '0) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rd_data;
`ifdef SYNC_MEM_PARITY_EN
                  rsp_err   <= rd_perr;
                  err_code  <= rd_perr ? ERR_PARITY : ERR_NONE;
`else
                  rsp_err   <= 1'b0;
                  err_code  <= ERR_NONE;
`endif
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               // Writes and errors arrive with rsp_valid low and raise it one edge later.
               if (!rsp_valid) begin
                  rsp_valid <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  err_code  <= ERR_NONE;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_mem_team1.sv
// Bench for sync_mem_team1: unit 0 uses RD_LAT=1, unit 1 uses RD_LAT=4.
// Parity scenario is compiled in when SYNC_MEM_PARITY_EN is defined.
module tb_sync_mem_team1;
   import sync_mem_team1_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n     [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_write [2];
   logic        req_read  [2];
   logic [11:0] req_addr  [2];
   logic [15:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [15:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic [1:0]  err_code  [2];

   int assertions = 0;
   int failures   = 0;
   int lat_of [2] = '{1, 4};
   logic [15:0] model [int];

   always #5 clk = ~clk;

   sync_mem_team1 #(.DATA_W(16), .ADDR_W(12), .RD_LAT(1), .PROT_ADDR(12'h000)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_read(req_read[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
      .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .err_code(err_code[0]));

   sync_mem_team1 #(.DATA_W(16), .ADDR_W(12), .RD_LAT(4), .PROT_ADDR(12'h000)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_read(req_read[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
      .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .err_code(err_code[1]));

   // Waits for req_ready, presents one request for exactly one accepting edge.
   task automatic accept(input int u, input bit wr, input bit rd,
                         input logic [11:0] addr, input logic [15:0] wdata);
      int w = 0;
      while (req_ready[u] !== 1'b1 && w < 50) begin
         @(negedge clk);
         w++;
      end
      req_valid[u] = 1'b1; req_write[u] = wr; req_read[u] = rd;
      req_addr[u]  = addr; req_wdata[u] = wdata;
      @(negedge clk);
      req_valid[u] = 1'b0; req_write[u] = 1'b0; req_read[u] = 1'b0;
   endtask

   // Full transaction: returns observed latency, response fields and protocol flags.
   task automatic do_req(input int u, input bit wr, input bit rd,
                         input logic [11:0] addr, input logic [15:0] wdata, input int hold,
                         output int lat, output logic [15:0] rdata, output logic err,
                         output logic [1:0] code, output bit stable, output bit post_ok);
      accept(u, wr, rd, addr, wdata);
      stable = 1'b1;
      lat    = 0;
      while (rsp_valid[u] !== 1'b1 && lat < 20) begin
         if (req_ready[u] !== 1'b0) stable = 1'b0;
         @(negedge clk);
         lat++;
      end
      rdata = rsp_rdata[u]; err = rsp_err[u]; code = err_code[u];
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         if ({rsp_valid[u], req_ready[u], rsp_rdata[u], rsp_err[u], err_code[u]}
             !== {1'b1, 1'b0, rdata, err, code}) stable = 1'b0;
      end
      rsp_ready[u] = 1'b1;
      @(negedge clk);
      post_ok = (rsp_valid[u] === 1'b0) && (req_ready[u] === 1'b1);
      rsp_ready[u] = 1'b0;
   endtask

   task automatic test_reset();
      for (int u = 0; u < 2; u++) begin
         rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_write[u] = 1'b0; req_read[u] = 1'b0;
         req_addr[u] = '0; req_wdata[u] = '0; rsp_ready[u] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         assertions++;
         if ({req_ready[u], rsp_valid[u], rsp_err[u], err_code[u], rsp_rdata[u]} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs u%0d: got rdy=%b vld=%b err=%b code=%b rdata=%h required all 0",
                     u, req_ready[u], rsp_valid[u], rsp_err[u], err_code[u], rsp_rdata[u]);
         end
         rst_n[u] = 1'b1;
      end
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         assertions++;
         if (req_ready[u] !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready u%0d: got %b required 1", u, req_ready[u]);
         end
      end
   endtask

   task automatic test_basic();
      int lat; logic [15:0] rd; logic er; logic [1:0] cd; bit st, po;
      do_req(0, 1, 0, 12'h010, 16'hBEEF, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({lat[7:0], rd, er, cd, st, po} !== {8'd1, 16'h0000, 1'b0, ERR_NONE, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL basic_write: got lat=%0d rdata=%h err=%b code=%b st=%b po=%b required lat=1 rdata=0 err=0 code=00 st=1 po=1",
                  lat, rd, er, cd, st, po);
      end
      do_req(0, 0, 1, 12'h010, 16'h0000, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({lat[7:0], rd, er, cd, st, po} !== {8'd1, 16'hBEEF, 1'b0, ERR_NONE, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL basic_read: got lat=%0d rdata=%h err=%b code=%b st=%b po=%b required lat=1 rdata=beef err=0 code=00",
                  lat, rd, er, cd, st, po);
      end
   endtask

   task automatic test_protect();
      int lat; logic [15:0] rd; logic er; logic [1:0] cd; bit st, po;
      do_req(0, 0, 1, 12'h000, 16'h0000, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({lat[7:0], rd, er, cd} !== {8'd1, 16'h0000, 1'b1, ERR_PROT}) begin
         failures++;
         $display("FAIL prot_read: got lat=%0d rdata=%h err=%b code=%b required lat=1 rdata=0 err=1 code=01",
                  lat, rd, er, cd);
      end
      do_req(0, 1, 0, 12'h000, 16'h5A3C, 1, lat, rd, er, cd, st, po);
      assertions++;
      if ({er, cd, st, po} !== {1'b1, ERR_PROT, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL prot_write: got err=%b code=%b st=%b po=%b required err=1 code=01 st=1 po=1",
                  er, cd, st, po);
      end
      assertions++;
`ifdef SYNC_MEM_PARITY_EN
      if (dut0.u_array.mem[0][15:0] === 16'h5A3C) begin
`else
      if (dut0.u_array.mem[0] === 16'h5A3C) begin
`endif
         failures++;
         $display("FAIL prot_array_untouched: got 5a3c required any other value");
      end
   endtask

   task automatic test_illegal();
      int lat; logic [15:0] rd; logic er; logic [1:0] cd; bit st, po;
      do_req(0, 1, 0, 12'h020, 16'hA5A5, 0, lat, rd, er, cd, st, po);
      do_req(0, 1, 1, 12'h020, 16'h1111, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({lat[7:0], rd, er, cd} !== {8'd1, 16'h0000, 1'b1, ERR_CMD}) begin
         failures++;
         $display("FAIL illegal_both: got lat=%0d rdata=%h err=%b code=%b required lat=1 rdata=0 err=1 code=10",
                  lat, rd, er, cd);
      end
      do_req(0, 0, 0, 12'h020, 16'h2222, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({er, cd} !== {1'b1, ERR_CMD}) begin
         failures++;
         $display("FAIL illegal_none: got err=%b code=%b required err=1 code=10", er, cd);
      end
      do_req(0, 0, 1, 12'h020, 16'h0000, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({rd, er} !== {16'hA5A5, 1'b0}) begin
         failures++;
         $display("FAIL illegal_array_kept: got rdata=%h err=%b required a5a5 err=0", rd, er);
      end
   endtask

   task automatic test_latency_hold();
      int lat; logic [15:0] rd; logic er; logic [1:0] cd; bit st, po;
      do_req(1, 1, 0, 12'h040, 16'hC3C3, 0, lat, rd, er, cd, st, po);
      do_req(1, 0, 1, 12'h040, 16'h0000, 3, lat, rd, er, cd, st, po);
      assertions++;
      if ({lat[7:0], rd, er, cd, st, po} !== {8'd4, 16'hC3C3, 1'b0, ERR_NONE, 1'b1, 1'b1}) begin
         failures++;
         $display("FAIL lat4_hold: got lat=%0d rdata=%h err=%b code=%b stable=%b post=%b required lat=4 rdata=c3c3 stable=1 post=1",
                  lat, rd, er, cd, st, po);
      end
   endtask

   task automatic test_reset_mid_op();
      int lat; logic [15:0] rd; logic er; logic [1:0] cd; bit st, po;
      do_req(1, 1, 0, 12'h050, 16'h7777, 0, lat, rd, er, cd, st, po);
      accept(1, 0, 1, 12'h050, 16'h0000);
      @(negedge clk);
      rst_n[1] = 1'b0;
      @(negedge clk);
      assertions++;
      if ({rsp_valid[1], req_ready[1]} !== 2'b00) begin
         failures++;
         $display("FAIL reset_mid_read: got vld=%b rdy=%b required 0 0", rsp_valid[1], req_ready[1]);
      end
      rst_n[1] = 1'b1;
      @(negedge clk);
      accept(1, 1, 0, 12'h060, 16'h8888);
      @(negedge clk);
      rst_n[1] = 1'b0;
      @(negedge clk);
      rst_n[1] = 1'b1;
      @(negedge clk);
      do_req(1, 0, 1, 12'h050, 16'h0000, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({lat[7:0], rd, er} !== {8'd4, 16'h7777, 1'b0}) begin
         failures++;
         $display("FAIL after_reset_read: got lat=%0d rdata=%h err=%b required lat=4 rdata=7777", lat, rd, er);
      end
      do_req(1, 0, 1, 12'h060, 16'h0000, 0, lat, rd, er, cd, st, po);
      assertions++;
      if (rd !== 16'h8888) begin
         failures++;
         $display("FAIL committed_write_kept: got %h required 8888", rd);
      end
   endtask

   task automatic test_back_to_back();
      for (int u = 0; u < 2; u++) begin
         int acc [$];
         int w = 0;
         req_valid[u] = 1'b1; req_read[u] = 1'b1; req_addr[u] = 12'h010; rsp_ready[u] = 1'b1;
         for (int c = 0; c < 40; c++) begin
            if (req_ready[u] === 1'b1) acc.push_back(c);
            @(negedge clk);
         end
         req_valid[u] = 1'b0; req_read[u] = 1'b0;
         while (req_ready[u] !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
         end
         rsp_ready[u] = 1'b0;
         assertions++;
         if (acc.size() < 5) begin
            failures++;
            $display("FAIL b2b_count u%0d: got %0d accepts required at least 5", u, acc.size());
         end else begin
            for (int i = 1; i < 5; i++) begin
               assertions++;
               if (acc[i] - acc[i-1] != lat_of[u] + 2) begin
                  failures++;
                  $display("FAIL b2b_period u%0d: got %0d cycles required %0d", u, acc[i] - acc[i-1], lat_of[u] + 2);
               end
            end
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         int u = n % 2;
         int r = $urandom_range(0, 9);
         bit wr, rd;
         logic [11:0] addr = 12'($urandom_range(0, 15));
         logic [15:0] wd = 16'($urandom);
         int lat; logic [15:0] ord; logic oer; logic [1:0] ocd; bit st, po;
         int exp_lat; logic [1:0] exp_cd; logic [15:0] exp_rd; bit know;
         if (r == 0) begin wr = $urandom_range(0, 1); rd = wr; end
         else if (r < 5) begin wr = 1'b1; rd = 1'b0; end
         else begin wr = 1'b0; rd = 1'b1; end
         exp_lat = 1; exp_rd = '0; know = 1'b1;
         if (wr == rd)             exp_cd = ERR_CMD;
         else if (addr == 12'h000) exp_cd = ERR_PROT;
         else if (wr) begin
            exp_cd = ERR_NONE;
            model[u * 4096 + int'(addr)] = wd;
         end else begin
            exp_cd  = ERR_NONE;
            exp_lat = lat_of[u];
            know    = model.exists(u * 4096 + int'(addr));
            if (know) exp_rd = model[u * 4096 + int'(addr)];
         end
         do_req(u, wr, rd, addr, wd, $urandom_range(0, 2), lat, ord, oer, ocd, st, po);
         assertions++;
         if ({lat[7:0], oer, ocd, st, po} !== {8'(exp_lat), exp_cd != ERR_NONE, exp_cd, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL rand_rsp u%0d addr=%h wr=%b rd=%b: got lat=%0d err=%b code=%b st=%b po=%b required lat=%0d code=%b",
                     u, addr, wr, rd, lat, oer, ocd, st, po, exp_lat, exp_cd);
         end
         if (know) begin
            assertions++;
            if (ord !== exp_rd) begin
               failures++;
               $display("FAIL rand_rdata u%0d addr=%h: got %h required %h", u, addr, ord, exp_rd);
            end
         end
      end
   endtask

`ifdef SYNC_MEM_PARITY_EN
   task automatic test_parity();
      int lat; logic [15:0] rd; logic er; logic [1:0] cd; bit st, po;
      do_req(0, 1, 0, 12'h030, 16'h0001, 0, lat, rd, er, cd, st, po);
      dut0.u_array.mem[12'h030][16] = ~dut0.u_array.mem[12'h030][16];
      do_req(0, 0, 1, 12'h030, 16'h0000, 0, lat, rd, er, cd, st, po);
      assertions++;
      if ({rd, er, cd} !== {16'h0001, 1'b1, ERR_PARITY}) begin
         failures++;
         $display("FAIL parity_err: got rdata=%h err=%b code=%b required 0001 1 11", rd, er, cd);
      end
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_protect();
      test_illegal();
      test_latency_hold();
      test_reset_mid_op();
      test_back_to_back();
      test_random();
`ifdef SYNC_MEM_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
